// File: rtl/sccb_init_ctrl.sv
// sccb_init_ctrl: SCCB master that plays a camera init table out of an external ROM.
// Each ROM entry is {reg_addr, data}; a reg_addr of all ones is a delay of data ms.
// Optional feature macro: SCCB_ACK_CHECK_EN (check slave ACKs, retry NACKed entries).
// nack_err and err_idx read as zero when the macro is not defined.
module sccb_init_ctrl #(
  parameter int         CLK_FREQ_HZ = 25_000_000,
  parameter int         SCL_FREQ_HZ = 100_000,
  parameter logic [6:0] DEV_ADDR    = 7'h21,
  parameter int         REG_ADDR_W  = 8,
  parameter int         NUM_REGS    = 64,
  parameter int         RETRY_MAX   = 2
) (
  input  logic                        clk_25m,
  input  logic                        rst_n,
  input  logic                        start,
  output logic [$clog2(NUM_REGS)-1:0] rom_addr,
  input  logic [REG_ADDR_W+7:0]       rom_data,
  output logic                        scl,
  output logic                        sda_oe,
  input  logic                        sda_i,
  output logic                        busy,
  output logic                        init_done,
  output logic                        nack_err,
  output logic [$clog2(NUM_REGS)-1:0] err_idx
);

  localparam int AW        = $clog2(NUM_REGS);
  localparam int QDIV_RAW  = CLK_FREQ_HZ / (4 * SCL_FREQ_HZ);
  localparam int QDIV      = (QDIV_RAW < 1) ? 1 : QDIV_RAW;
  localparam int MS_CYCLES = CLK_FREQ_HZ / 1000;
  localparam int NBYTES    = 2 + REG_ADDR_W / 8;
  localparam int FW        = 8 * NBYTES;

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_LATCH, S_DELAY, S_START, S_BYTE,
    S_STOP, S_GAP, S_NEXT, S_DONE, S_ERR
  } state_t;

  state_t        state;
  logic [31:0]   tick_cnt;
  logic          tick;
  logic [FW-1:0] frame_sr;
  logic [3:0]    bit_cnt;
  logic [2:0]    byte_cnt;
  logic [1:0]    q;
  logic [31:0]   delay_cnt;
  logic          abort;

`ifdef SCCB_ACK_CHECK_EN
  logic          nack_flag;
  logic [7:0]    retry_cnt;
  logic          nack_err_r;
  logic [AW-1:0] err_idx_r;

  assign abort    = nack_flag;
  assign nack_err = nack_err_r;
  assign err_idx  = err_idx_r;
`else
  logic unused_sda;

  assign unused_sda = sda_i;
  assign abort      = 1'b0;
  assign nack_err   = 1'b0;
  assign err_idx    = '0;
`endif

  // Quarter-bit tick generator, free-running only while a sequence is active
  always_ff @(posedge clk_25m) begin
    if (!rst_n || !busy)
      tick_cnt <= '0;
    else if (tick_cnt == 32'(QDIV - 1))
      tick_cnt <= '0;
    else
      tick_cnt <= tick_cnt + 32'd1;
  end

  assign tick = busy && (tick_cnt == 32'(QDIV - 1));

  // Sequencer: walks the ROM, frames each entry as START/bytes/STOP and drives the pads
  always_ff @(posedge clk_25m) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      scl       <= 1'b1;
      sda_oe    <= 1'b0;
      busy      <= 1'b0;
      init_done <= 1'b0;
      rom_addr  <= '0;
      frame_sr  <= '0;
      bit_cnt   <= '0;
      byte_cnt  <= '0;
      q         <= '0;
      delay_cnt <= '0;
`ifdef SCCB_ACK_CHECK_EN
      nack_flag  <= 1'b0;
      retry_cnt  <= '0;
      nack_err_r <= 1'b0;
      err_idx_r  <= '0;
`endif
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            rom_addr  <= '0;
            busy      <= 1'b1;
            init_done <= 1'b0;
`ifdef SCCB_ACK_CHECK_EN
            nack_flag  <= 1'b0;
            retry_cnt  <= '0;
            nack_err_r <= 1'b0;
`endif
            state <= S_LOAD;
          end
        end
        S_LOAD: state <= S_LATCH;
        S_LATCH: begin
          frame_sr  <= {DEV_ADDR, 1'b0, rom_data};
          delay_cnt <= 32'(rom_data[7:0]) * 32'(MS_CYCLES);
          q         <= '0;
          if (rom_data[REG_ADDR_W+7:8] == '1)
            state <= S_DELAY;
          else
            state <= S_START;
        end
        S_DELAY: begin
          if (delay_cnt == 32'd0)
            state <= S_NEXT;
          else
            delay_cnt <= delay_cnt - 32'd1;
        end
        S_START: begin
          if (tick) begin
            if (q == 2'd0) begin
              sda_oe <= 1'b1;
              q      <= 2'd1;
            end else begin
              scl      <= 1'b0;
              q        <= 2'd0;
              bit_cnt  <= '0;
              byte_cnt <= '0;
              state    <= S_BYTE;
            end
          end
        end
        S_BYTE: begin
          if (tick) begin
            q <= q + 2'd1;
            case (q)
              2'd0: begin
                scl    <= 1'b0;
                sda_oe <= (bit_cnt == 4'd8) ? 1'b0 : ~frame_sr[FW-1];
              end
              2'd1: scl <= 1'b0;
              2'd2: begin
                scl <= 1'b1;
`ifdef SCCB_ACK_CHECK_EN
                if (bit_cnt == 4'd8 && sda_i)
                  nack_flag <= 1'b1;
`endif
              end
              default: begin
                scl <= 1'b1;
                if (bit_cnt == 4'd8) begin
                  bit_cnt  <= '0;
                  byte_cnt <= byte_cnt + 3'd1;
                  if (byte_cnt == 3'(NBYTES - 1) || abort)
                    state <= S_STOP;
                end else begin
                  bit_cnt  <= bit_cnt + 4'd1;
                  frame_sr <= {frame_sr[FW-2:0], 1'b0};
                end
              end
            endcase
          end
        end
        S_STOP: begin
          if (tick) begin
            case (q)
              2'd0: begin
                scl    <= 1'b0;
                sda_oe <= 1'b1;
                q      <= 2'd1;
              end
              2'd1: begin
                scl <= 1'b1;
                q   <= 2'd2;
              end
              default: begin
                sda_oe <= 1'b0;
                q      <= 2'd0;
                state  <= S_GAP;
              end
            endcase
          end
        end
        S_GAP: begin
          if (tick) begin
            q <= q + 2'd1;
            if (q == 2'd3) begin
`ifdef SCCB_ACK_CHECK_EN
              if (nack_flag) begin
                nack_flag <= 1'b0;
                if (retry_cnt == 8'(RETRY_MAX)) begin
                  nack_err_r <= 1'b1;
                  err_idx_r  <= rom_addr;
                  busy       <= 1'b0;
                  retry_cnt  <= '0;
                  state      <= S_ERR;
                end else begin
                  retry_cnt <= retry_cnt + 8'd1;
                  state     <= S_LOAD;
                end
              end else begin
                retry_cnt <= '0;
                state     <= S_NEXT;
              end
`else
              state <= S_NEXT;
`endif
            end
          end
        end
        S_NEXT: begin
          if (rom_addr == AW'(NUM_REGS - 1)) begin
            busy      <= 1'b0;
            init_done <= 1'b1;
            state     <= S_DONE;
          end else begin
            rom_addr <= rom_addr + AW'(1);
            state    <= S_LOAD;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
